// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [0:0] {
        eSTABLE,
        eSETTLING
    } debounce_state_e;

    // 10 ms at 12 MHz
    localparam int unsigned default_stable_cycles_lp = 120000;

endpackage

// File: rtl/dff.sv
// Single D flop with synchronous active-high reset to a parameterised value.
module dff #(
    parameter logic reset_val_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic q_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_reg <= reset_val_p;
        end else begin
            q_reg <= d_i;
        end
    end

    assign q_o = q_reg;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchroniser bringing an asynchronous pin into clk_i; reusable for any pin.
module synchronizer #(
    parameter logic reset_val_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    localparam int stages_lp = 2;

    logic [stages_lp:0] chain;

    assign chain[0] = d_i;

    generate
        for (genvar gi = 0; gi < stages_lp; gi++) begin : g_stage
            dff #(
                .reset_val_p(reset_val_p)
            ) u_dff (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .d_i    (chain[gi]),
                .q_o    (chain[gi+1])
            );
        end
    endgenerate

    assign q_o = chain[stages_lp];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button/switch pin: synchronise, then require stable_cycles_p
// consecutive mismatching cycles before the clean level follows the pin.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned stable_cycles_p = default_stable_cycles_lp,
    parameter logic        reset_val_p     = 1'b0,
    parameter int unsigned bounce_width_p  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      d_i,
    output logic                      q_o,
    output logic                      settling_o,
    output logic [bounce_width_p-1:0] bounces_o
);

    localparam int count_width_lp = $clog2(stable_cycles_p + 1);
    localparam logic [count_width_lp-1:0] count_last_lp = count_width_lp'(stable_cycles_p - 1);
    localparam logic [bounce_width_p-1:0] bounce_max_lp = {bounce_width_p{1'b1}};

    logic                      sync_level;
    logic                      mismatch;
    debounce_state_e           state_reg, state_next;
    logic [count_width_lp-1:0] count_reg, count_next;
    logic                      q_reg, q_next;
    logic [bounce_width_p-1:0] bounces_reg, bounces_next;

    synchronizer #(
        .reset_val_p(reset_val_p)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (d_i),
        .q_o    (sync_level)
    );

    assign mismatch = (sync_level != q_reg);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= eSTABLE;
            count_reg   <= '0;
            q_reg       <= reset_val_p;
            bounces_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            q_reg       <= q_next;
            bounces_reg <= bounces_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        q_next       = q_reg;
        bounces_next = bounces_reg;
        unique case (state_reg)
            eSTABLE: begin
                count_next = '0;
                if (mismatch) begin
                    // A single-cycle filter has nothing to count; flip immediately.
                    if (stable_cycles_p == 1) begin
                        q_next = ~q_reg;
                    end else begin
                        state_next = eSETTLING;
                        count_next = count_width_lp'(1);
                    end
                end
            end
            eSETTLING: begin
                if (mismatch) begin
                    if (count_reg == count_last_lp) begin
                        q_next     = ~q_reg;
                        state_next = eSTABLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + count_width_lp'(1);
                    end
                end else begin
                    // Level bounced back before settling: abort and log it.
                    state_next = eSTABLE;
                    count_next = '0;
                    if (bounces_reg != bounce_max_lp) begin
                        bounces_next = bounces_reg + bounce_width_p'(1);
                    end
                end
            end
            default: begin
                state_next = eSTABLE;
                count_next = '0;
            end
        endcase
    end

    assign q_o        = q_reg;
    assign settling_o = (state_reg == eSETTLING);
    assign bounces_o  = bounces_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with hand-computed expectations.
module tb_button_debouncer;

    logic       clk;
    logic       rst_a, d_a;
    logic       q_a, settling_a;
    logic [7:0] bounces_a;
    logic       rst_b, d_b;
    logic       q_b, settling_b;
    logic [7:0] bounces_b;

    int vec_cnt;
    int err_cnt;

    button_debouncer #(
        .stable_cycles_p(4),
        .reset_val_p    (1'b0),
        .bounce_width_p (8)
    ) dut_a (
        .clk_i     (clk),
        .reset_i   (rst_a),
        .d_i       (d_a),
        .q_o       (q_a),
        .settling_o(settling_a),
        .bounces_o (bounces_a)
    );

    button_debouncer #(
        .stable_cycles_p(1),
        .reset_val_p    (1'b1),
        .bounce_width_p (8)
    ) dut_b (
        .clk_i     (clk),
        .reset_i   (rst_b),
        .d_i       (d_b),
        .q_o       (q_b),
        .settling_o(settling_b),
        .bounces_o (bounces_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One active edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_a = 1'b1; d_a = 1'b0;
        rst_b = 1'b1; d_b = 1'b1;
        #2;

        // Reset state, then d_i low held for 20 cycles.
        reset_a();
        check("rst_q", q_a, 0);
        check("rst_settling", settling_a, 0);
        check("rst_bounces", bounces_a, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold0_q[%0d]", i), q_a, 0);
            check($sformatf("hold0_settling[%0d]", i), settling_a, 0);
        end
        check("hold0_bounces", bounces_a, 0);

        // Rising settle: edges 0..5 with d_i held high.
        d_a = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check($sformatf("rise_settling[e%0d]", e), settling_a, (e >= 2 && e <= 4) ? 1 : 0);
            check($sformatf("rise_q[e%0d]", e), q_a, (e == 5) ? 1 : 0);
        end

        // Falling settle is filtered identically.
        d_a = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check($sformatf("fall_settling[e%0d]", e), settling_a, (e >= 2 && e <= 4) ? 1 : 0);
            check($sformatf("fall_q[e%0d]", e), q_a, (e == 5) ? 0 : 1);
        end
        check("fall_bounces", bounces_a, 0);

        // Three-cycle pulse is one short of settling: settle aborts at edge 5.
        reset_a();
        d_a = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            if (e == 3) d_a = 1'b0;
            tick();
            check($sformatf("glitch_q[e%0d]", e), q_a, 0);
            check($sformatf("glitch_settling[e%0d]", e), settling_a, (e >= 2 && e <= 4) ? 1 : 0);
        end
        check("glitch_bounces", bounces_a, 1);

        // Single-cycle pulses each abort one settle; counter saturates at 255.
        reset_a();
        for (int p = 1; p <= 300; p++) begin
            d_a = 1'b1;
            tick();
            d_a = 1'b0;
            tick();
            tick();
            tick();
            if (p == 254) check("sat_bounces_254", bounces_a, 254);
            if (p == 255) check("sat_bounces_255", bounces_a, 255);
            if (p == 256) check("sat_bounces_256", bounces_a, 255);
        end
        check("sat_bounces_300", bounces_a, 255);
        check("sat_q", q_a, 0);

        // Reset in the middle of a rising settle.
        reset_a();
        d_a = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        check("midrst_settling_pre", settling_a, 1);
        rst_a = 1'b1;
        tick();
        check("midrst_q", q_a, 0);
        check("midrst_settling", settling_a, 0);
        check("midrst_bounces", bounces_a, 0);
        rst_a = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check($sformatf("midrst_q[e%0d]", e), q_a, (e == 5) ? 1 : 0);
        end

        // stable_cycles_p=1, reset to 1: falling pin reaches q_o after edge 2.
        rst_b = 1'b1;
        d_b   = 1'b1;
        tick();
        check("one_rst_q", q_b, 1);
        rst_b = 1'b0;
        d_b   = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            tick();
            check($sformatf("one_q[e%0d]", e), q_b, (e >= 2) ? 0 : 1);
            check($sformatf("one_settling[e%0d]", e), settling_b, 0);
        end
        check("one_bounces", bounces_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
